score_scan: RTL and testbench

//  Upstream feeder for the 7-segment decoder stage. Converts a 14-bit binary score to 4 BCD digits

---
 rtl/score_scan.sv | 180 ++++++++++++++++++
 tb/tb_score_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/score_scan.sv
// rtl/score_scan.sv - 14-bit binary score to 4 BCD digits via double dabble, time-multiplexed per refresh slot.
// Optional ATOMIC_UPDATE_EN: results go through a shadow register and reach the display only at frame start.
module score_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int VALUE_W     = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [3:0]         seg_number,
  output logic [1:0]         an_number
);

  localparam int                 CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(9999);
  localparam logic [4:0]         LAST_BIT = 5'(VALUE_W - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_bit_cnt;
  logic [15:0]          r_bcd;
  logic [VALUE_W-1:0]   r_bin;
  logic                 r_pend;
  logic [VALUE_W-1:0]   r_pend_val;
  logic                 r_ovf;
  logic [15:0]          r_digits;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_an;
  logic [3:0]           r_seg;

  logic                 w_start;
  logic [VALUE_W-1:0]   w_src;
  logic                 w_over;
  logic [VALUE_W-1:0]   w_clamped;
  logic [15:0]          w_bcd_adj;
  logic [VALUE_W+15:0]  w_dd;
  logic                 w_term;
  logic [1:0]           w_an_nxt;
  logic [15:0]          w_digits_nxt;
  logic [3:0]           w_seg_nxt;

  // A load arriving in DONE wins over the pending value (latest wins).
  assign w_start   = ((r_state == S_IDLE) && load) ||
                     ((r_state == S_DONE) && (load || r_pend));
  assign w_src     = load ? value : r_pend_val;
  assign w_over    = (w_src > MAX_VAL);
  assign w_clamped = w_over ? MAX_VAL : w_src;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign w_dd = {w_bcd_adj, r_bin} << 1;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_bit_cnt == LAST_BIT) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = w_start ? S_SHIFT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_start) begin
        r_bin     <= w_clamped;
        r_bcd     <= '0;
        r_bit_cnt <= '0;
        r_ovf     <= w_over;
        r_pend    <= 1'b0;
      end else begin
        if (r_state == S_SHIFT) begin
          r_bcd     <= w_dd[VALUE_W+15:VALUE_W];
          r_bin     <= w_dd[VALUE_W-1:0];
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        if (load) begin
          r_pend     <= 1'b1;
          r_pend_val <= value;
        end
      end
    end
  end

  assign w_term   = (r_cnt == CNT_LAST);
  assign w_an_nxt = w_term ? r_an + 2'd1 : r_an;

`ifdef ATOMIC_UPDATE_EN
  logic [15:0] r_shadow;
  logic        w_frame_end;

  assign w_frame_end = w_term && (r_an == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (r_state == S_DONE) begin
      r_shadow <= r_bcd;
    end
  end

  always_comb begin
    w_digits_nxt = r_digits;
    if (w_frame_end) w_digits_nxt = r_shadow;
  end
`else
  always_comb begin
    w_digits_nxt = r_digits;
    if (r_state == S_DONE) w_digits_nxt = r_bcd;
  end
`endif

  // Select from next-state values so seg_number always matches an_number and the digit regs.
  always_comb begin
    w_seg_nxt = w_digits_nxt[15:12];
    case (w_an_nxt)
      2'd0:    w_seg_nxt = w_digits_nxt[15:12];
      2'd1:    w_seg_nxt = w_digits_nxt[11:8];
      2'd2:    w_seg_nxt = w_digits_nxt[7:4];
      default: w_seg_nxt = w_digits_nxt[3:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= '0;
      r_cnt    <= '0;
      r_an     <= '0;
      r_seg    <= '0;
    end else begin
      r_digits <= w_digits_nxt;
      r_cnt    <= w_term ? '0 : r_cnt + 1'b1;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  assign ovf        = r_ovf;
  assign seg_number = r_seg;
  assign an_number  = r_an;

endmodule

// File: tb/tb_score_scan.sv
// tb/tb_score_scan.sv - randomized and directed bench for score_scan against a transaction-level model.
module tb_score_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        busy, done, ovf;
  logic [3:0]  seg_number;
  logic [1:0]  an_number;

  int n_checks = 0;
  int n_errors = 0;
  int obs_done = 0;

  // Model: age 0 = idle, 1..14 = shifting, 15 = done cycle.
  int m_age, m_cur, m_pend, m_pend_val, m_ovf, m_disp, m_shadow, m_an, m_cnt;

  score_scan #(.REFRESH_DIV(DIV), .VALUE_W(14)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .done(done), .ovf(ovf),
    .seg_number(seg_number), .an_number(an_number)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_of(input int v, input int slot);
    int p = 1;
    for (int i = slot; i < 3; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  task automatic model_reset();
    m_age = 0; m_cur = 0; m_pend = 0; m_pend_val = 0; m_ovf = 0;
    m_disp = 0; m_shadow = 0; m_an = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit ld, input int v);
    bit start, term, boundary;
    int src;
    start    = (m_age == 0 && ld) || (m_age == 15 && (ld || m_pend != 0));
    term     = (m_cnt == DIV - 1);
    boundary = term && (m_an == 3);
`ifdef ATOMIC_UPDATE_EN
    if (boundary) m_disp = m_shadow;
    if (m_age == 15) m_shadow = m_cur;
`else
    if (m_age == 15) m_disp = m_cur;
`endif
    m_cnt = term ? 0 : m_cnt + 1;
    if (term) m_an = (m_an + 1) % 4;
    if (start) begin
      src   = ld ? v : m_pend_val;
      m_ovf = (src > 9999) ? 1 : 0;
      m_cur = (src > 9999) ? 9999 : src;
      m_pend = 0;
      m_age  = 1;
    end else begin
      if (ld && m_age != 0) begin
        m_pend = 1;
        m_pend_val = v;
      end
      if (m_age == 15) m_age = 0;
      else if (m_age > 0) m_age++;
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), (m_age != 0) ? 1 : 0);
    check("done", 32'(done), (m_age == 15) ? 1 : 0);
    check("ovf", 32'(ovf), m_ovf);
    check("an_number", 32'(an_number), m_an);
    check("seg_number", 32'(seg_number), digit_of(m_disp, m_an));
  endtask

  // Invariant: called just after a falling edge.
  task automatic cyc(input bit ld, input int v);
    load  = ld;
    value = 14'(v);
    @(posedge clk);
    model_edge(ld, v);
    #1;
    if (done) obs_done++;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0);
  endtask

  task automatic do_reset();
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_seg", 32'(seg_number), 0);
    check("rst_an", 32'(an_number), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int d0;

  initial begin
    model_reset();
    #1;
    check("init_busy", 32'(busy), 0);
    check("init_seg", 32'(seg_number), 0);
    check("init_an", 32'(an_number), 0);
    @(negedge clk);
    rst = 1'b0;

    idle(6);
    cyc(1'b1, 1234);
    idle(40);
    do_reset();
    idle(20);

    cyc(1'b1, 12000);
    idle(40);
    cyc(1'b1, 7);
    idle(40);

    d0 = obs_done;
    cyc(1'b1, 4321);
    idle(4);
    cyc(1'b1, 56);
    idle(50);
    check("two_done_pulses", obs_done - d0, 2);

    d0 = obs_done;
    cyc(1'b1, 9999);
    idle(6);
    do_reset();
    idle(30);
    check("no_done_after_abort", obs_done - d0, 0);

    cyc(1'b1, 1111);
    idle(20);
    cyc(1'b1, 2222);
    idle(40);

    // Load coinciding with the done cycle, and a burst of loads while busy.
    cyc(1'b1, 500);
    idle(14);
    cyc(1'b1, 9000);
    idle(5);
    cyc(1'b1, 10);
    cyc(1'b1, 16383);
    cyc(1'b1, 42);
    idle(50);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        cyc(1'b1, (($urandom_range(0, 3) == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999)));
      end else begin
        cyc(1'b0, 0);
      end
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
